// File: rtl/icache_core_if.sv
// icache_core_if: CPU fetch handshake plus line-refill bus of the instruction cache.
// master = fetch stage / refill engine side, slave = cache side.
interface icache_core_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  cpu_req_valid;
  logic [ADDR_WIDTH-1:0] cpu_req_addr;
  logic                  cpu_req_ready;
  logic                  cpu_resp_valid;
  logic [31:0]           cpu_resp_data;

  logic [ADDR_WIDTH-1:0] refill_addr;
  logic                  refill_start;
  logic                  refill_busy;
  logic                  refill_done;
  logic [31:0]           refill_data;
  logic [1:0]            refill_word;
  logic                  refill_data_valid;

  modport master (
    output cpu_req_valid, cpu_req_addr,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
    input  refill_addr, refill_start,
    output refill_busy, refill_done, refill_data, refill_word, refill_data_valid
  );

  modport slave (
    input  cpu_req_valid, cpu_req_addr,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
    output refill_addr, refill_start,
    input  refill_busy, refill_done, refill_data, refill_word, refill_data_valid
  );
endinterface

// File: rtl/icache_core.sv
// icache_core: direct-mapped read-only instruction cache, 16-byte lines, 4-beat refill.
// Define ICACHE_PERF_CNT_EN to build the saturating hit/miss counters.
module icache_core #(
  parameter int NUM_LINES  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  icache_core_if.slave cif,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, REFILL} state_t;
  state_t state;

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [31:0]           data_mem [NUM_LINES][4];

  logic [ADDR_WIDTH-1:2] addr_p1;
  logic [31:0]           fill_word;
  logic                  flush_pending;
  logic                  resp_valid_q;
  logic [31:0]           resp_data_q;
  logic                  refill_start_q;
  logic [ADDR_WIDTH-1:0] refill_addr_q;

  logic [1:0]            off;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  flush_apply;
  logic                  req_ready;
  logic                  req_fire;
  logic                  hit;
  logic                  beat_en;
  logic                  done_en;
  logic [31:0]           fill_data;
  logic                  unused_addr_lo;

  assign off = addr_p1[3:2];
  assign idx = addr_p1[IDX_W+3:4];
  assign tag = addr_p1[ADDR_WIDTH-1:IDX_W+4];
  assign unused_addr_lo = ^cif.cpu_req_addr[1:0];

  // Flush is applied only from IDLE so an in-flight refill can finish first.
  assign flush_apply = (state == IDLE) && (flush || flush_pending);
  assign req_ready   = rst_n && (state == IDLE) && !flush_apply;
  assign req_fire    = cif.cpu_req_valid && req_ready;
  assign hit         = valid_q[idx] && (tag_mem[idx] == tag);
  assign beat_en     = (state == REFILL) && cif.refill_data_valid;
  assign done_en     = (state == REFILL) && cif.refill_done;
  assign fill_data   = (beat_en && (cif.refill_word == off)) ? cif.refill_data : fill_word;

  assign cif.cpu_req_ready  = req_ready;
  assign cif.cpu_resp_valid = resp_valid_q;
  assign cif.cpu_resp_data  = resp_data_q;
  assign cif.refill_start   = refill_start_q;
  assign cif.refill_addr    = refill_addr_q;

  // Stage p1: latched request address, refill capture and storage arrays (no reset).
  always_ff @(posedge clk) begin
    if (req_fire) addr_p1 <= cif.cpu_req_addr[ADDR_WIDTH-1:2];
    if (beat_en) begin
      data_mem[idx][cif.refill_word] <= cif.refill_data;
      if (cif.refill_word == off) fill_word <= cif.refill_data;
    end
    if (done_en) tag_mem[idx] <= tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      valid_q        <= '0;
      flush_pending  <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      refill_start_q <= 1'b0;
      refill_addr_q  <= '0;
    end else begin
      resp_valid_q   <= 1'b0;
      refill_start_q <= 1'b0;
      if (flush_apply) begin
        valid_q       <= '0;
        flush_pending <= 1'b0;
      end else if (flush) begin
        flush_pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (req_fire) state <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= data_mem[idx][off];
            state        <= IDLE;
          end else begin
            state <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (!cif.refill_busy) begin
            refill_start_q <= 1'b1;
            refill_addr_q  <= {addr_p1[ADDR_WIDTH-1:4], 4'h0};
            state          <= REFILL;
          end
        end
        REFILL: begin
          // A beat coinciding with done is already folded into fill_data.
          if (cif.refill_done) begin
            valid_q[idx] <= 1'b1;
            resp_valid_q <= 1'b1;
            resp_data_q  <= fill_data;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
      else     miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_core.sv
// tb_icache_core: scoreboard bench for icache_core; memory word at byte A is 0xA0000000 + A/4.
// Counter expectations follow ICACHE_PERF_CNT_EN (zero when undefined).
module tb_icache_core;
  localparam int NUM_LINES  = 64;
  localparam int ADDR_WIDTH = 32;
`ifdef ICACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_core_if #(.ADDR_WIDTH(ADDR_WIDTH)) cif ();

  icache_core #(.NUM_LINES(NUM_LINES), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cif(cif),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          starts = 0;
  int          acc_to = 0;
  int          accept_cyc = 0;
  int          obs_rd = 0;
  int          hits_m = 0;
  int          misses_m = 0;
  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];
  int          obs_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cif.cpu_resp_valid) begin
        obs_q.push_back(cif.cpu_resp_data);
        obs_cyc.push_back(cyc);
      end
      if (cif.refill_start) starts++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [31:0] a);
    int n = 0;
    cif.cpu_req_valid = 1'b1;
    cif.cpu_req_addr  = a;
    #1;
    while (cif.cpu_req_ready !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (cif.cpu_req_ready !== 1'b1) acc_to++;
    else exp_q.push_back(mem_word(a));
    accept_cyc = cyc;
    @(negedge clk);
    cif.cpu_req_valid = 1'b0;
  endtask

  task automatic serve_refill(input logic [7:0] order, input bit coincide, input int flush_beat,
                              input int reset_beat, output logic [31:0] addr, output bit to);
    int n = 0;
    while (cif.refill_start !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    to   = (cif.refill_start !== 1'b1);
    addr = cif.refill_addr;
    if (to) return;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b == reset_beat) begin
        rst_n = 1'b0;
        cif.refill_data_valid = 1'b0;
        flush = 1'b0;
        return;
      end
      cif.refill_word       = order[2*b +: 2];
      cif.refill_data       = mem_word(addr + {28'd0, order[2*b +: 2], 2'b00});
      cif.refill_data_valid = 1'b1;
      cif.refill_done       = coincide && (b == 3);
      flush                 = (b == flush_beat);
    end
    @(negedge clk);
    cif.refill_data_valid = 1'b0;
    flush = 1'b0;
    if (!coincide) begin
      cif.refill_done = 1'b1;
      @(negedge clk);
    end
    cif.refill_done = 1'b0;
  endtask

  task automatic sb_next(output logic [31:0] got, output logic [31:0] want, output bit none);
    int n = 0;
    while (obs_rd >= obs_q.size() && n < 60) begin
      @(negedge clk); n++;
    end
    none = (obs_rd >= obs_q.size()) || (exp_q.size() == 0);
    got  = 32'hx;
    want = 32'hx;
    if (!none) begin
      want = exp_q.pop_front();
      got  = obs_q[obs_rd];
      obs_rd++;
    end
  endtask

  task automatic stray_beats();
    for (int b = 0; b < 3; b++) begin
      cif.refill_word       = b[1:0];
      cif.refill_data       = 32'hDEAD_BEEF;
      cif.refill_data_valid = 1'b1;
      cif.refill_done       = (b == 2);
      @(negedge clk);
    end
    cif.refill_data_valid = 1'b0;
    cif.refill_done       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (cif.cpu_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b want=0", cif.cpu_req_ready); end
    n_cmp++; if (cif.cpu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got=%b want=0", cif.cpu_resp_valid); end
    n_cmp++; if (cif.cpu_resp_data !== 32'h0) begin n_bad++; $display("FAIL rst_resp_data got=%h want=0", cif.cpu_resp_data); end
    n_cmp++; if (cif.refill_start !== 1'b0) begin n_bad++; $display("FAIL rst_refill_start got=%b want=0", cif.refill_start); end
    n_cmp++; if (cif.refill_addr !== 32'h0) begin n_bad++; $display("FAIL rst_refill_addr got=%h want=0", cif.refill_addr); end
    n_cmp++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_bad++; $display("FAIL rst_counters got=%0d/%0d want=0/0", hit_count, miss_count); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (cif.cpu_req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready got=%b want=1", cif.cpu_req_ready); end
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    logic [31:0] ra, got, want;
    bit to, none;
    int s0 = starts;
    issue(32'h104);
    serve_refill(8'hE4, 1'b0, -1, -1, ra, to);
    n_cmp++; if (to || ra !== 32'h100) begin n_bad++; $display("FAIL cold_refill_addr got=%h timeout=%b want=00000100", ra, to); end
    sb_next(got, want, none);
    misses_m++;
    n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL cold_resp got=%h want=%h", got, want); end
    n_cmp++; if (starts - s0 != 1) begin n_bad++; $display("FAIL cold_start_count got=%0d want=1", starts - s0); end
    n_cmp++; if (miss_count !== 32'(PERF ? misses_m : 0)) begin n_bad++; $display("FAIL cold_miss_count got=%0d want=%0d", miss_count, PERF ? misses_m : 0); end
  endtask

  task automatic test_hit();
    logic [31:0] got, want;
    bit none;
    int s0 = starts;
    issue(32'h10C);
    sb_next(got, want, none);
    hits_m++;
    n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL hit_resp got=%h want=%h", got, want); end
    n_cmp++; if (!none && obs_cyc[obs_rd-1] - accept_cyc != 2) begin n_bad++; $display("FAIL hit_latency got=%0d want=2", obs_cyc[obs_rd-1] - accept_cyc); end
    n_cmp++; if (starts != s0) begin n_bad++; $display("FAIL hit_no_refill got=%0d want=0", starts - s0); end
    n_cmp++; if (hit_count !== 32'(PERF ? hits_m : 0)) begin n_bad++; $display("FAIL hit_count got=%0d want=%0d", hit_count, PERF ? hits_m : 0); end
  endtask

  task automatic test_conflict();
    logic [31:0] ra, got, want;
    bit to, none;
    issue(32'h500);
    serve_refill(8'h87, 1'b1, -1, -1, ra, to);
    n_cmp++; if (to || ra !== 32'h500) begin n_bad++; $display("FAIL evict_refill_addr got=%h timeout=%b want=00000500", ra, to); end
    sb_next(got, want, none);
    n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL evict_resp got=%h want=%h", got, want); end
    issue(32'h100);
    serve_refill(8'h1B, 1'b0, -1, -1, ra, to);
    n_cmp++; if (to || ra !== 32'h100) begin n_bad++; $display("FAIL refetch_refill_addr got=%h timeout=%b want=00000100", ra, to); end
    sb_next(got, want, none);
    n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL refetch_resp got=%h want=%h", got, want); end
    misses_m += 2;
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, want;
    bit none;
    int a1;
    issue(32'h100);
    a1 = accept_cyc;
    issue(32'h108);
    n_cmp++; if (accept_cyc - a1 != 2) begin n_bad++; $display("FAIL b2b_accept_gap got=%0d want=2", accept_cyc - a1); end
    for (int k = 0; k < 2; k++) begin
      sb_next(got, want, none);
      n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL b2b_resp%0d got=%h want=%h", k, got, want); end
    end
    hits_m += 2;
  endtask

  task automatic test_flush();
    logic [31:0] ra, got, want;
    bit to, none;
    issue(32'h200);
    serve_refill(8'hE4, 1'b0, -1, -1, ra, to);
    sb_next(got, want, none);
    n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL flush_fill_resp got=%h want=%h", got, want); end
    repeat (2) @(negedge clk);
    flush = 1'b1;
    cif.cpu_req_valid = 1'b1;
    cif.cpu_req_addr  = 32'h200;
    #1;
    n_cmp++; if (cif.cpu_req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready_low got=%b want=0", cif.cpu_req_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++; if (cif.cpu_req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready_back got=%b want=1", cif.cpu_req_ready); end
    issue(32'h200);
    serve_refill(8'hE4, 1'b0, 1, -1, ra, to);
    n_cmp++; if (to || ra !== 32'h200) begin n_bad++; $display("FAIL flush_miss_refill got=%h timeout=%b want=00000200", ra, to); end
    sb_next(got, want, none);
    n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL flush_refill_resp got=%h want=%h", got, want); end
    issue(32'h200);
    serve_refill(8'hE4, 1'b0, -1, -1, ra, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL flush_during_refill_miss got=timeout want=refill_start"); end
    sb_next(got, want, none);
    n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL flush_after_resp got=%h want=%h", got, want); end
    misses_m += 3;
  endtask

  task automatic test_busy();
    logic [31:0] ra, got, want;
    bit to, none;
    int s0 = starts;
    cif.refill_busy = 1'b1;
    issue(32'h300);
    repeat (5) @(negedge clk);
    n_cmp++; if (starts != s0) begin n_bad++; $display("FAIL busy_no_start got=%0d want=0", starts - s0); end
    cif.refill_busy = 1'b0;
    serve_refill(8'hE4, 1'b0, -1, -1, ra, to);
    n_cmp++; if (to || ra !== 32'h300) begin n_bad++; $display("FAIL busy_refill_addr got=%h timeout=%b want=00000300", ra, to); end
    sb_next(got, want, none);
    n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL busy_resp got=%h want=%h", got, want); end
    n_cmp++; if (starts - s0 != 1) begin n_bad++; $display("FAIL busy_single_start got=%0d want=1", starts - s0); end
    misses_m++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] ra, got, want;
    bit to, none;
    int s0;
    issue(32'h600);
    serve_refill(8'hE4, 1'b0, -1, 2, ra, to);
    #1;
    n_cmp++;
    if ({cif.cpu_req_ready, cif.cpu_resp_valid, cif.refill_start} !== 3'b000 ||
        cif.cpu_resp_data !== 32'h0 || cif.refill_addr !== 32'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
      n_bad++;
      $display("FAIL midrst_outputs got rdy=%b rv=%b rs=%b rd=%h ra=%h hc=%0d mc=%0d want all 0",
               cif.cpu_req_ready, cif.cpu_resp_valid, cif.refill_start, cif.cpu_resp_data,
               cif.refill_addr, hit_count, miss_count);
    end
    exp_q.delete();
    hits_m = 0;
    misses_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray_beats();
    n_cmp++; if (obs_q.size() != obs_rd) begin n_bad++; $display("FAIL midrst_no_resp got=%0d want=0", obs_q.size() - obs_rd); end
    issue(32'h600);
    serve_refill(8'hE4, 1'b0, -1, -1, ra, to);
    n_cmp++; if (to || ra !== 32'h600) begin n_bad++; $display("FAIL midrst_remiss got=%h timeout=%b want=00000600", ra, to); end
    sb_next(got, want, none);
    n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL midrst_resp got=%h want=%h", got, want); end
    stray_beats();
    s0 = starts;
    issue(32'h604);
    sb_next(got, want, none);
    n_cmp++; if (none || got !== want) begin n_bad++; $display("FAIL stray_hit_resp got=%h want=%h", got, want); end
    n_cmp++; if (starts != s0) begin n_bad++; $display("FAIL stray_hit_no_refill got=%0d want=0", starts - s0); end
    misses_m++;
    hits_m++;
    n_cmp++;
    if (hit_count !== 32'(PERF ? hits_m : 0) || miss_count !== 32'(PERF ? misses_m : 0)) begin
      n_bad++;
      $display("FAIL midrst_counters got=%0d/%0d want=%0d/%0d", hit_count, miss_count,
               PERF ? hits_m : 0, PERF ? misses_m : 0);
    end
  endtask

  task automatic test_final();
    repeat (4) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0 || obs_q.size() != obs_rd) begin n_bad++; $display("FAIL sb_drain got exp_left=%0d obs_left=%0d want=0/0", exp_q.size(), obs_q.size() - obs_rd); end
    n_cmp++; if (acc_to != 0) begin n_bad++; $display("FAIL accept_timeouts got=%0d want=0", acc_to); end
  endtask

  initial begin
    cif.cpu_req_valid     = 1'b0;
    cif.cpu_req_addr      = '0;
    cif.refill_busy       = 1'b0;
    cif.refill_done       = 1'b0;
    cif.refill_data       = '0;
    cif.refill_word       = '0;
    cif.refill_data_valid = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_busy();
    test_reset_mid();
    test_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
